branch_redirect_ctrl: RTL and testbench
=======================================

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width of PC, immediate and redirect target.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of each statistics counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 ex_valid  input  1  SHALL indicate that the EX stage holds a valid instruction.
REQ-006 ex_is_branch  input  1  SHALL indicate that the EX instruction is B-type.
REQ-007 branch_taken  input  1  SHALL carry the resolved condition from the branch comparator.
REQ-008 pred_taken  input  1  SHALL carry the fetch-time prediction for this instruction.
REQ-009 ex_pc  input  XLEN  SHALL carry the PC of the EX instruction.
REQ-010 ex_imm  input  XLEN  SHALL carry the sign-extended B-type immediate.
REQ-011 redir_ready  input  1  SHALL indicate that fetch accepts the redirect this cycle.
REQ-012 redir_valid  output  1  SHALL indicate that a redirect request is pending.
REQ-013 redir_pc  output  XLEN  SHALL carry the corrected fetch address.
REQ-014 flush_if_id  output  1  SHALL kill the IF/ID register contents.
REQ-015 flush_id_ex  output  1  SHALL kill the ID/EX register contents.
REQ-016 stall_ex  output  1  SHALL freeze EX and earlier stages.
REQ-017 misalign  output  1  SHALL be a one-cycle pulse flagging a taken target with bit 1 set.
REQ-018 branch_count  output  CNT_W  SHALL count resolved branches.
REQ-019 mispred_count  output  CNT_W  SHALL count mispredicted branches.

Function
REQ-020 The FSM SHALL have three states: IDLE, REDIRECT and DRAIN; only IDLE accepts new branch events.
REQ-021 A resolve event SHALL be defined as ex_valid & ex_is_branch & state==IDLE.
REQ-022 A mispredict SHALL be defined as a resolve event with branch_taken != pred_taken.
REQ-023 On a mispredict the block SHALL capture the target: ex_pc+ex_imm if branch_taken, else ex_pc+4.
REQ-024 Target arithmetic SHALL be modulo 2^XLEN (wrap-around, no carry out); bit 0 of the target SHALL be forced to 0.
REQ-025 On a mispredict the FSM SHALL move IDLE->REDIRECT at the next edge.
REQ-026 In REDIRECT the block SHALL assert redir_valid, flush_if_id, flush_id_ex and stall_ex, and SHALL hold redir_pc stable.
REQ-027 In REDIRECT with redir_ready=1 the FSM SHALL move to DRAIN; with redir_ready=0 it SHALL remain in REDIRECT indefinitely.
REQ-028 DRAIN SHALL last exactly 1 cycle with flush_if_id=1 and all other control outputs 0, then return to IDLE.
REQ-029 A correct prediction SHALL leave the FSM in IDLE with no flush and no stall.
REQ-030 All inputs SHALL be ignored in REDIRECT and DRAIN, except redir_ready in REDIRECT.
REQ-031 misalign SHALL pulse in the cycle after a mispredict whose taken target has bit 1 set; the redirect SHALL still proceed.
REQ-032 branch_count SHALL increment on every resolve event.
REQ-033 mispred_count SHALL increment on every mispredict.
REQ-034 Both counters SHALL wrap from all-ones to 0.
REQ-035 All outputs SHALL be registered or decoded from state only; no input-to-output combinational path is permitted.
REQ-036 The redirect latency SHALL be 1 cycle, from the mispredict cycle to the first cycle of redir_valid.

Reset
REQ-037 While rst=1 the FSM SHALL be IDLE, all 1-bit outputs SHALL be 0, and redir_pc, branch_count and mispred_count SHALL be 0.
REQ-038 A rst assertion in REDIRECT or DRAIN SHALL drop redir_valid and the flushes immediately, without waiting for clk; the captured target SHALL be discarded.

Verification
REQ-039 ex_pc=0x100, ex_imm=0x20, taken=1, pred=0, redir_ready=1 -> next cycle redir_valid=1, redir_pc=0x120 and both flushes high; cycle after, DRAIN; mispred_count=1.
REQ-040 ex_pc=0x200, taken=0, pred=1, redir_ready low for 3 cycles -> redir_valid and stall_ex held for 4 cycles with redir_pc=0x204, then DRAIN, then IDLE.
REQ-041 taken=pred=1 on 5 consecutive cycles -> branch_count=5, mispred_count=0, no flush or stall.
REQ-042 ex_pc=0xFFFFFFF0, ex_imm=0x14, taken=1, pred=0 -> redir_pc=0x00000004 (wrap); ex_imm=0x12 instead -> redir_pc=0x00000002 with a misalign pulse.
REQ-043 rst asserted mid-REDIRECT -> outputs 0 before the next clk edge; after release, IDLE with counters 0.
REQ-044 branch_count preset to all-ones via 2^CNT_W-1 resolves, then one more resolve -> branch_count=0.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
// Resolves B-type branches in EX against the fetch-time prediction. On a
// mispredict it captures the corrected fetch address, raises a redirect to
// fetch, and flushes the younger pipeline stages until fetch accepts it. It
// also keeps wrapping counters of resolved and mispredicted branches.
//
// State sequence after a mispredict:
//   IDLE -> REDIRECT (held while redir_ready=0) -> DRAIN (1 cycle) -> IDLE
// Every control output is either a register or a decode of the state, so no
// input reaches an output through combinational logic alone.
// -----------------------------------------------------------------------------
module branch_redirect_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             branch_taken,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             redir_ready,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_pc,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             stall_ex,
    output logic             misalign,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REDIRECT = 2'd1;
    localparam logic [1:0] DRAIN    = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic            resolve;
    logic            mispredict;
    logic [XLEN-1:0] taken_target;
    logic [XLEN-1:0] fallthru_target;
    logic [XLEN-1:0] target;

    // A branch only counts while IDLE; REDIRECT and DRAIN ignore EX entirely.
    assign resolve    = ex_valid & ex_is_branch & (state == IDLE);
    assign mispredict = resolve & (branch_taken != pred_taken);

    // Both sums are XLEN wide, so the carry out is dropped and the address wraps.
    assign taken_target    = ex_pc + ex_imm;
    assign fallthru_target = ex_pc + XLEN'(4);

    // Pick the corrected path and force the halfword-alignment bit 0 low.
    always_comb begin
        target = (branch_taken ? taken_target : fallthru_target) & ~XLEN'(1);
    end

    // Next-state logic for the redirect sequence.
    always_comb begin
        // NOTE: assign a default before the case so every path drives state_next; otherwise a latch is inferred.
        state_next = state;
        case (state)
            IDLE:     if (mispredict)  state_next = REDIRECT;
            REDIRECT: if (redir_ready) state_next = DRAIN;
            DRAIN:                     state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // State register; reset returns to IDLE without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Capture the corrected fetch address; it stays put through REDIRECT and DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             redir_pc <= '0;
        else if (mispredict) redir_pc <= target;
    end

    // One-cycle pulse when a taken mispredict lands on a target with bit 1 set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign <= 1'b0;
        else     misalign <= mispredict & branch_taken & target[1];
    end

    // Statistics counters; natural binary overflow gives the all-ones -> 0 wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else begin
            if (resolve)    branch_count  <= branch_count + CNT_W'(1);
            if (mispredict) mispred_count <= mispred_count + CNT_W'(1);
        end
    end

    // Control outputs are pure state decodes, so an async reset clears them at once.
    assign redir_valid = (state == REDIRECT);
    assign flush_id_ex = (state == REDIRECT);
    assign stall_ex    = (state == REDIRECT);
    assign flush_if_id = (state == REDIRECT) || (state == DRAIN);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect_ctrl
// Table-driven vectors, hand-written multi-cycle sequences, then random
// stimulus compared against a cycle-level reference model. Counters are
// narrowed to 8 bits so the wrap-around case stays short.
// -----------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

    localparam int XLEN = 32;
    localparam int CW   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid, ex_is_branch, branch_taken, pred_taken, redir_ready;
    logic [XLEN-1:0] ex_pc, ex_imm;
    logic            redir_valid, flush_if_id, flush_id_ex, stall_ex, misalign;
    logic [XLEN-1:0] redir_pc;
    logic [CW-1:0]   branch_count, mispred_count;

    int n_vec = 0;
    int n_err = 0;

    branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .branch_taken(branch_taken), .pred_taken(pred_taken),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .redir_ready(redir_ready),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .stall_ex(stall_ex), .misalign(misalign),
        .branch_count(branch_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A pending redirect, a pending drain cycle, the address handed to fetch,
    // the misalign flag, and two wrapping tallies.
    bit              m_pending;
    bit              m_drain;
    logic [XLEN-1:0] m_pc;
    bit              m_mis;
    logic [CW-1:0]   m_bc, m_mc;

    task automatic model_reset();
        m_pending = 0; m_drain = 0; m_pc = '0; m_mis = 0; m_bc = '0; m_mc = '0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        logic [XLEN:0] sum;
        m_mis = 0;
        if (m_pending) begin
            if (redir_ready) begin m_pending = 0; m_drain = 1; end
        end else if (m_drain) begin
            m_drain = 0;
        end else if (ex_valid && ex_is_branch) begin
            m_bc = m_bc + 1'b1;
            if (branch_taken != pred_taken) begin
                m_mc = m_mc + 1'b1;
                sum  = {1'b0, ex_pc} + (branch_taken ? {1'b0, ex_imm} : 33'd4);
                m_pc = sum[XLEN-1:0] & 32'hFFFF_FFFE;
                m_mis = branch_taken && m_pc[1];
                m_pending = 1;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic br, input logic t, input logic p,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                        input logic rdy);
        ex_valid = v; ex_is_branch = br; branch_taken = t; pred_taken = p;
        ex_pc = pc; ex_imm = imm; redir_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_step(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, rdy);
    endtask

    task automatic check_ctrl(input string tag, input logic rv, input logic f1,
                              input logic f2, input logic st);
        check({tag, ".redir_valid"}, 64'(redir_valid), 64'(rv));
        check({tag, ".flush_if_id"}, 64'(flush_if_id), 64'(f1));
        check({tag, ".flush_id_ex"}, 64'(flush_id_ex), 64'(f2));
        check({tag, ".stall_ex"},    64'(stall_ex),    64'(st));
    endtask

    task automatic check_model(input string tag);
        check_ctrl(tag, m_pending, m_pending | m_drain, m_pending, m_pending);
        check({tag, ".redir_pc"},      64'(redir_pc),      64'(m_pc));
        check({tag, ".misalign"},      64'(misalign),      64'(m_mis));
        check({tag, ".branch_count"},  64'(branch_count),  64'(m_bc));
        check({tag, ".mispred_count"}, 64'(mispred_count), 64'(m_mc));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            v, br, t, p;
        logic [XLEN-1:0] pc, imm;
        logic            rdy;
        logic            rv;
        logic [XLEN-1:0] rpc;
        logic            f1, f2, st, mis;
    } vec_t;

    vec_t tbl[17];

    initial begin
        //              v  br t  p  pc             imm           rdy  rv rpc            f1 f2 st mis
        tbl[0]  = '{1, 1, 1, 0, 32'h0000_0100, 32'h0000_0020, 1,  1, 32'h0000_0120, 1, 1, 1, 0};
        tbl[1]  = '{1, 1, 1, 0, 32'h0000_0500, 32'h0000_0004, 1,  0, 32'h0000_0120, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  0, 32'h0000_0120, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 1, 0, 32'hFFFF_FFF0, 32'h0000_0014, 0,  1, 32'h0000_0004, 1, 1, 1, 0};
        tbl[4]  = '{1, 1, 0, 1, 32'h0000_0700, 32'h0000_0008, 1,  0, 32'h0000_0004, 1, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 1,  0, 32'h0000_0004, 0, 0, 0, 0};
        tbl[6]  = '{1, 1, 1, 0, 32'hFFFF_FFF0, 32'h0000_0012, 0,  1, 32'h0000_0002, 1, 1, 1, 1};
        tbl[7]  = '{0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 1,  0, 32'h0000_0002, 1, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  0, 32'h0000_0002, 0, 0, 0, 0};
        tbl[9]  = '{1, 1, 1, 1, 32'h0000_0400, 32'h0000_0010, 0,  0, 32'h0000_0002, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 1, 0, 32'h0000_0400, 32'h0000_0010, 0,  0, 32'h0000_0002, 0, 0, 0, 0};
        tbl[11] = '{1, 1, 1, 0, 32'h0000_0300, 32'h0000_0011, 0,  1, 32'h0000_0310, 1, 1, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 1,  0, 32'h0000_0310, 1, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  0, 32'h0000_0310, 0, 0, 0, 0};
        tbl[14] = '{1, 1, 0, 1, 32'h0000_0202, 32'h0000_0040, 0,  1, 32'h0000_0206, 1, 1, 1, 0};
        tbl[15] = '{0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 1,  0, 32'h0000_0206, 1, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0,  0, 32'h0000_0206, 0, 0, 0, 0};
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        ex_valid = 0; ex_is_branch = 0; branch_taken = 0; pred_taken = 0;
        ex_pc = '0; ex_imm = '0; redir_ready = 0;
        model_reset();

        // Reset state while rst is held across clock edges.
        repeat (3) @(posedge clk);
        #1;
        check_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.misalign", 64'(misalign), 64'd0);
        check("reset.redir_pc", 64'(redir_pc), 64'd0);
        check("reset.branch_count", 64'(branch_count), 64'd0);
        check("reset.mispred_count", 64'(mispred_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table.
        for (int i = 0; i < 17; i++) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            step(tbl[i].v, tbl[i].br, tbl[i].t, tbl[i].p, tbl[i].pc, tbl[i].imm, tbl[i].rdy);
            check_ctrl(tag, tbl[i].rv, tbl[i].f1, tbl[i].f2, tbl[i].st);
            check({tag, ".redir_pc"}, 64'(redir_pc), 64'(tbl[i].rpc));
            check({tag, ".misalign"}, 64'(misalign), 64'(tbl[i].mis));
        end
        // Resolves at rows 0,3,6,9,11,14; mispredicts at rows 0,3,6,11,14.
        check("tbl.branch_count", 64'(branch_count), 64'd6);
        check("tbl.mispred_count", 64'(mispred_count), 64'd5);

        // Not-taken mispredict with fetch stalled for three REDIRECT cycles.
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0100, 1'b1);
        for (int c = 0; c < 4; c++) begin
            string tag;
            tag = $sformatf("hold%0d", c);
            check_ctrl(tag, 1'b1, 1'b1, 1'b1, 1'b1);
            check({tag, ".redir_pc"}, 64'(redir_pc), 64'h204);
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0900, 32'h0000_0010, (c == 3));
        end
        check_ctrl("hold.drain", 1'b0, 1'b1, 1'b0, 1'b0);
        idle_step(1'b0);
        check_ctrl("hold.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold.mispred_count", 64'(mispred_count), 64'd6);

        // Asynchronous reset in the middle of REDIRECT.
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0040, 1'b0);
        check_ctrl("prerst", 1'b1, 1'b1, 1'b1, 1'b1);
        #3 rst = 1'b1;
        #1;
        check_ctrl("asyncrst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("asyncrst.redir_pc", 64'(redir_pc), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_step(1'b1);
        check_ctrl("postrst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("postrst.branch_count", 64'(branch_count), 64'd0);
        check("postrst.mispred_count", 64'(mispred_count), 64'd0);

        // Five correct predictions back to back.
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2000 + 32'(4 * c), 32'h0000_0080, 1'b0);
            check_ctrl($sformatf("correct%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("correct.branch_count", 64'(branch_count), 64'd5);
        check("correct.mispred_count", 64'(mispred_count), 64'd0);

        // Branch counter wrap from all-ones to zero.
        do_reset();
        for (int c = 0; c < (1 << CW) - 1; c++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_0010, 1'b0);
        check("wrap.branch_count_max", 64'(branch_count), 64'((1 << CW) - 1));
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_0010, 1'b0);
        check("wrap.branch_count_zero", 64'(branch_count), 64'd0);
        check("wrap.mispred_count", 64'(mispred_count), 64'd0);

        // Random stimulus against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [XLEN-1:0] pc, imm;
            pc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 pc, imm, $urandom_range(0, 2) != 0);
            check_model($sformatf("rand%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
